// File: rtl/ddr_cmd_decode.sv
// DDR4 command/address front end: decodes the sampled bus into registered one-cycle
// strobes and watches tRRD/tFAW spacing between decoded activates.
module ddr_cmd_decode #(
  parameter int BGW   = 2,
  parameter int BAW   = 2,
  parameter int AW    = 18,
  parameter int T_RRD = 4,
  parameter int T_FAW = 16,
  localparam int BW   = BGW + BAW,
  localparam int NB   = 2 ** BW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cke,
  input  logic          cs_n,
  input  logic          act_n,
  input  logic          ras_n,
  input  logic          cas_n,
  input  logic          we_n,
  input  logic [BGW-1:0] bg,
  input  logic [BAW-1:0] ba,
  input  logic [AW-1:0] addr,
  output logic [NB-1:0] act_o,
  output logic [NB-1:0] rd_o,
  output logic [NB-1:0] rda_o,
  output logic [NB-1:0] wr_o,
  output logic [NB-1:0] wra_o,
  output logic [NB-1:0] pr_o,
  output logic          pra_o,
  output logic          ref_o,
  output logic          srf_o,
  output logic          pd_o,
  output logic          pdx_o,
  output logic          ckeh_o,
  output logic          ckel_o,
  output logic          mrw_o,
  output logic [BW-1:0] bank_o,
  output logic [AW-1:0] row_o,
  output logic [9:0]    col_o,
  output logic          rrd_viol,
  output logic          faw_viol,
  output logic          illegal
);

  localparam int RRD_CW = $clog2(T_RRD + 1);
  localparam int FAW_CW = $clog2(T_FAW + 1);

  logic              cke_q;
  logic [RRD_CW-1:0] rrd_cnt;
  logic [FAW_CW-1:0] faw_slot [4];

  logic [2:0]    rcw;
  logic [BW-1:0] bidx;
  logic [NB-1:0] bsel;
  logic is_cmd, is_act, is_mrs, is_ref, is_pre, is_wr, is_rd, is_idle;
  logic mode_norm, mode_enter, mode_exit;
  logic d_act, d_mrs, d_ref, d_pre, d_wr, d_rd, d_banked, ill_set;
  logic       faw_free;
  logic [1:0] faw_sel;

  always_comb begin
    rcw     = {ras_n, cas_n, we_n};
    bidx    = {bg, ba};
    bsel    = NB'(1) << bidx;
    is_act  = !cs_n && !act_n;
    is_cmd  = !cs_n && act_n;
    is_mrs  = is_cmd && (rcw == 3'b000);
    is_ref  = is_cmd && (rcw == 3'b001);
    is_pre  = is_cmd && (rcw == 3'b010);
    is_wr   = is_cmd && (rcw == 3'b100);
    is_rd   = is_cmd && (rcw == 3'b101);
    is_idle = cs_n || (is_cmd && (rcw == 3'b111));

    mode_norm  = cke_q && cke;
    mode_enter = cke_q && !cke;
    mode_exit  = !cke_q && cke;

    d_act    = mode_norm && is_act;
    d_mrs    = mode_norm && is_mrs;
    d_ref    = mode_norm && is_ref;
    d_pre    = mode_norm && is_pre;
    d_wr     = mode_norm && is_wr;
    d_rd     = mode_norm && is_rd;
    d_banked = d_act || d_rd || d_wr || (d_pre && !addr[10]);
    // Entering power-down only REF (self-refresh) or idle is legal; leaving it only idle.
    ill_set  = (mode_enter && !is_ref && !is_idle) || (mode_exit && !is_idle);
  end

  // Lowest-index free tFAW slot; a slot at zero in its registered value counts as free.
  always_comb begin
    faw_free = 1'b0;
    faw_sel  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (faw_slot[i] == '0) begin
        faw_free = 1'b1;
        faw_sel  = 2'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cke_q    <= 1'b1;
      act_o    <= '0;
      rd_o     <= '0;
      rda_o    <= '0;
      wr_o     <= '0;
      wra_o    <= '0;
      pr_o     <= '0;
      pra_o    <= 1'b0;
      ref_o    <= 1'b0;
      srf_o    <= 1'b0;
      pd_o     <= 1'b0;
      pdx_o    <= 1'b0;
      ckeh_o   <= 1'b0;
      ckel_o   <= 1'b0;
      mrw_o    <= 1'b0;
      bank_o   <= '0;
      row_o    <= '0;
      col_o    <= '0;
      rrd_viol <= 1'b0;
      faw_viol <= 1'b0;
      illegal  <= 1'b0;
      rrd_cnt  <= '0;
      for (int i = 0; i < 4; i++) faw_slot[i] <= '0;
    end else begin
      cke_q  <= cke;
      act_o  <= d_act ? bsel : '0;
      rd_o   <= (d_rd && !addr[10]) ? bsel : '0;
      rda_o  <= (d_rd && addr[10]) ? bsel : '0;
      wr_o   <= (d_wr && !addr[10]) ? bsel : '0;
      wra_o  <= (d_wr && addr[10]) ? bsel : '0;
      pr_o   <= (d_pre && !addr[10]) ? bsel : '0;
      pra_o  <= d_pre && addr[10];
      ref_o  <= d_ref;
      mrw_o  <= d_mrs;
      srf_o  <= mode_enter && is_ref;
      pd_o   <= mode_enter && is_idle;
      ckel_o <= mode_enter;
      ckeh_o <= mode_exit;
      pdx_o  <= mode_exit;

      if (d_banked) bank_o <= bidx;
      if (d_act) row_o <= addr;
      if (d_rd || d_wr) col_o <= addr[9:0];
      if (ill_set) illegal <= 1'b1;

      // Timing monitors: violations are flagged but the ACT is still forwarded.
      if (d_act) begin
        if (rrd_cnt != '0) rrd_viol <= 1'b1;
        rrd_cnt <= RRD_CW'(T_RRD - 1);
      end else if (rrd_cnt != '0) begin
        rrd_cnt <= rrd_cnt - RRD_CW'(1);
      end

      if (d_act && !faw_free) faw_viol <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (d_act && faw_free && (faw_sel == 2'(i)))
          faw_slot[i] <= FAW_CW'(T_FAW - 1);
        else if (faw_slot[i] != '0)
          faw_slot[i] <= faw_slot[i] - FAW_CW'(1);
      end
    end
  end

endmodule
